rv_mem_responder: RTL and testbench

- Memory-side endpoint for the cluster/L2 memory request/response interface.
- Accepts valid/ready requests (read or byte-enabled write) into an on-chip word array.
- Returns read data with the request tag after a fixed latency, through a response queue that honours backpressure.
- Used as the memory slave in cluster-level simulation and FPGA bring-up. It answers the cluster's arbiter output port.

---
 rtl/rv_mem_responder_pkg.sv | 26 ++
 rtl/rv_mem_rsp_queue.sv | 40 ++++
 rtl/rv_mem_responder.sv | 138 +++++++++++++
 tb/tb_rv_mem_responder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv_mem_responder_pkg.sv
// Shared widths, op encoding and response-entry packing for rv_mem_responder.
// Entries travel the delay line and queue as {tag, data}.
package rv_mem_responder_pkg;

    localparam int L2_MEM_DATA_WIDTH   = 512;
    localparam int L2_MEM_ADDR_WIDTH   = 26;
    localparam int L2_MEM_TAG_WIDTH    = 8;
    localparam int L2_MEM_BYTEEN_WIDTH = L2_MEM_DATA_WIDTH / 8;
    localparam int RSP_DEPTH_DEFAULT   = 8;
    localparam int CNT_W               = $clog2(RSP_DEPTH_DEFAULT) + 1;

    typedef enum logic {
        REQ_RD = 1'b0,
        REQ_WR = 1'b1
    } req_op_e;

    // Counter must reach RSP_DEPTH itself, hence the extra bit.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`ifndef RV_MEM_RSP_PACK
`define RV_MEM_RSP_PACK(tag, data) {(tag), (data)}
`endif

// File: rtl/rv_mem_rsp_queue.sv
// Response FIFO: DEPTH entries, head visible combinationally, 1-cycle push-to-head.
// No backpressure of its own: caller guarantees no push when full, no pop when empty.
module rv_mem_rsp_queue
    import rv_mem_responder_pkg::*;
#(
    parameter int DEPTH = RSP_DEPTH_DEFAULT,
    parameter int WIDTH = L2_MEM_TAG_WIDTH + L2_MEM_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_dat_o
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + 1'b1;
            if (pop_i)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q[PW-1:0]] <= push_dat_i;
    end

    assign empty_o    = (wptr_q == rptr_q);
    assign head_dat_o = mem_q[rptr_q[PW-1:0]];

endmodule

// File: rtl/rv_mem_responder.sv
// Memory-side endpoint: on-chip line array answering valid/ready reads and byte-enabled writes.
// Read latency LATENCY cycles (accept edge to earliest response handshake), in-order responses.
// Backpressure: mem_req_ready drops once RSP_DEPTH reads are outstanding; RV_MEM_WRITE_RSP_EN makes writes respond too.
module rv_mem_responder
    import rv_mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH     = L2_MEM_DATA_WIDTH,
    parameter int ADDR_WIDTH     = L2_MEM_ADDR_WIDTH,
    parameter int TAG_WIDTH      = L2_MEM_TAG_WIDTH,
    parameter int MEM_WORDS_LOG2 = 10,
    parameter int LATENCY        = 4,
    parameter int RSP_DEPTH      = RSP_DEPTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mem_req_valid,
    input  logic                    mem_req_rw,
    input  logic [DATA_WIDTH/8-1:0] mem_req_byteen,
    input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
    input  logic [DATA_WIDTH-1:0]   mem_req_data,
    input  logic [TAG_WIDTH-1:0]    mem_req_tag,
    output logic                    mem_req_ready,
    output logic                    mem_rsp_valid,
    output logic [DATA_WIDTH-1:0]   mem_rsp_data,
    output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
    input  logic                    mem_rsp_ready,
    output logic                    busy
);

    localparam int BYTES   = DATA_WIDTH / 8;
    localparam int CNT_WD  = cnt_w(RSP_DEPTH);
    localparam int ENTRY_W = TAG_WIDTH + DATA_WIDTH;
    localparam int STAGES  = LATENCY - 1;
    localparam logic [CNT_WD-1:0] FULL_CNT = CNT_WD'(RSP_DEPTH);

    logic [DATA_WIDTH-1:0]     mem_q [2**MEM_WORDS_LOG2];
    logic [MEM_WORDS_LOG2-1:0] idx;
    logic                      req_fire, wr_fire, rd_fire, rsp_fire, rsp_gen;
    logic [DATA_WIDTH-1:0]     rsp_dat;
    logic [ENTRY_W-1:0]        new_entry;
    logic                      dly_vld;
    logic [ENTRY_W-1:0]        dly_dat;
    logic                      q_empty;
    logic [ENTRY_W-1:0]        q_head;
    logic [ENTRY_W-1:0]        last_q;
    logic [CNT_WD-1:0]         cnt_q, cnt_d;
    logic                      unused_addr_hi;

    assign unused_addr_hi = ^mem_req_addr[ADDR_WIDTH-1:MEM_WORDS_LOG2];
    assign idx            = mem_req_addr[MEM_WORDS_LOG2-1:0];

    assign req_fire = mem_req_valid && mem_req_ready;
    assign wr_fire  = req_fire && (req_op_e'(mem_req_rw) == REQ_WR);
    assign rd_fire  = req_fire && (req_op_e'(mem_req_rw) == REQ_RD);
    assign rsp_fire = mem_rsp_valid && mem_rsp_ready;

`ifdef RV_MEM_WRITE_RSP_EN
    assign rsp_gen = req_fire;
    assign rsp_dat = wr_fire ? '0 : mem_q[idx];
`else
    assign rsp_gen = rd_fire;
    assign rsp_dat = mem_q[idx];
`endif

    // Snapshot is the pre-write array content, so a read never sees its own-cycle write.
    assign new_entry = `RV_MEM_RSP_PACK(mem_req_tag, rsp_dat);

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int b = 0; b < BYTES; b++) begin
                if (mem_req_byteen[b]) mem_q[idx][b*8 +: 8] <= mem_req_data[b*8 +: 8];
            end
        end
    end

    generate
        if (STAGES == 0) begin : g_nodly
            assign dly_vld = rsp_gen;
            assign dly_dat = new_entry;
        end else begin : g_dly
            logic [STAGES-1:0]  vld_q;
            logic [ENTRY_W-1:0] dat_q [STAGES];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    vld_q <= '0;
                end else begin
                    vld_q[0] <= rsp_gen;
                    for (int s = 1; s < STAGES; s++) vld_q[s] <= vld_q[s-1];
                end
            end

            always_ff @(posedge clk) begin
                if (rsp_gen) dat_q[0] <= new_entry;
                for (int s = 1; s < STAGES; s++) dat_q[s] <= dat_q[s-1];
            end

            assign dly_vld = vld_q[STAGES-1];
            assign dly_dat = dat_q[STAGES-1];
        end
    endgenerate

    // The credit gate on requests keeps the queue from overflowing, so the delay line never stalls.
    rv_mem_rsp_queue #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_rsp_queue (
        .clk        (clk),
        .rst_n      (reset),
        .push_i     (dly_vld),
        .push_dat_i (dly_dat),
        .pop_i      (rsp_fire),
        .empty_o    (q_empty),
        .head_dat_o (q_head)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (rsp_gen && !rsp_fire)      cnt_d = cnt_q + 1'b1;
        else if (!rsp_gen && rsp_fire) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            last_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (rsp_fire) last_q <= q_head;
        end
    end

    assign mem_req_ready = reset && (cnt_q < FULL_CNT);
    assign busy          = (cnt_q != '0);
    assign mem_rsp_valid = !q_empty;
    assign {mem_rsp_tag, mem_rsp_data} = q_empty ? last_q : q_head;

endmodule

// File: tb/tb_rv_mem_responder.sv
// Scoreboard bench for rv_mem_responder at default parameters (write responses disabled).
module tb_rv_mem_responder;

    localparam int DW  = 512;
    localparam int AW  = 26;
    localparam int TW  = 8;
    localparam int BW  = DW / 8;
    localparam int LAT = 4;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          req_vld, req_rw, req_rdy;
    logic [BW-1:0] req_be;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_dat, rsp_dat;
    logic [TW-1:0] req_tag, rsp_tag;
    logic          rsp_vld, rsp_rdy, busy;

    always #5 clk = ~clk;

    rv_mem_responder dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req_valid  (req_vld),
        .mem_req_rw     (req_rw),
        .mem_req_byteen (req_be),
        .mem_req_addr   (req_addr),
        .mem_req_data   (req_dat),
        .mem_req_tag    (req_tag),
        .mem_req_ready  (req_rdy),
        .mem_rsp_valid  (rsp_vld),
        .mem_rsp_data   (rsp_dat),
        .mem_rsp_tag    (rsp_tag),
        .mem_rsp_ready  (rsp_rdy),
        .busy           (busy)
    );

    typedef struct {
        logic [TW-1:0] tag;
        logic [DW-1:0] dat;
        int            acc_cyc;
        bit            chk_lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // Monitor: response handshakes at the next rising edge are decided here.
    always begin
        @(negedge clk);
        #1;
        if (reset && rsp_vld && rsp_rdy) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_rsp: got tag %0h, required no response", rsp_tag);
            end else begin
                mon_e = sb.pop_front();
                if (rsp_tag !== mon_e.tag || rsp_dat !== mon_e.dat) begin
                    n_err++;
                    $display("FAIL rsp_tag_data: got tag %0h data %0h, required tag %0h data %0h",
                             rsp_tag, rsp_dat, mon_e.tag, mon_e.dat);
                end
                if (mon_e.chk_lat) begin
                    n_cmp++;
                    if (cyc - mon_e.acc_cyc != LAT) begin
                        n_err++;
                        $display("FAIL rsp_latency: got %0d, required %0d", cyc - mon_e.acc_cyc, LAT);
                    end
                end
            end
        end
    end

    task automatic drive_wr(input logic [AW-1:0] a, input logic [BW-1:0] be, input logic [DW-1:0] d);
        @(negedge clk);
        req_vld = 1'b1; req_rw = 1'b1; req_addr = a; req_be = be; req_dat = d; req_tag = '0;
        chk("wr_ready", req_rdy, 1);
    endtask

    task automatic drive_rd(input logic [AW-1:0] a, input logic [TW-1:0] t, input logic [DW-1:0] xd,
                            input bit lat, output bit acc);
        exp_t e;
        @(negedge clk);
        req_vld = 1'b1; req_rw = 1'b0; req_addr = a; req_be = '0; req_dat = '0; req_tag = t;
        acc = req_rdy;
        if (acc) begin
            e.tag = t; e.dat = xd; e.acc_cyc = cyc; e.chk_lat = lat;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        req_vld = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #2;
            if (sb.size() == 0 && !rsp_vld) break;
        end
        chk(nm, sb.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            acc;
        logic [DW-1:0] all_a5, part, zero, pat, pat3c;
        logic [BW-1:0] be_all;

        all_a5 = {64{8'hA5}};
        part   = {{63{8'hA5}}, 8'h5A};
        zero   = '0;
        pat    = {16{32'h1234_5678}};
        pat3c  = {64{8'h3C}};
        be_all = '1;

        req_vld = 0; req_rw = 0; req_be = '0; req_addr = '0; req_dat = '0; req_tag = '0;
        rsp_rdy = 0;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rsp_valid", rsp_vld, 0);
        chk("rst_rsp_data", rsp_dat, zero);
        chk("rst_rsp_tag", rsp_tag, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_rdy, 0);
        rsp_rdy = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        #1 chk("ready_after_release", req_rdy, 1);

        // Full write then read-after-write with latency check
        drive_wr(26'h010, be_all, all_a5);
        drive_rd(26'h010, 8'h3, all_a5, 1, acc);
        idle();
        wait_drain("drain_full_write");

        // Byte-0 partial write
        drive_wr(26'h010, 64'h1, {{63{8'h00}}, 8'h5A});
        drive_rd(26'h010, 8'h4, part, 1, acc);
        idle();
        wait_drain("drain_partial");

        // Fill all credits with the consumer stalled
        rsp_rdy = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive_rd(26'h010, TW'(i), part, 0, acc);
            chk($sformatf("bp_accept_%0d", i), acc, (i < 8) ? 1 : 0);
        end
        chk("bp_busy", busy, 1);
        idle();
        repeat (6) @(negedge clk);
        chk("full_ready_low", req_rdy, 0);
        rsp_rdy = 1'b1;
        @(negedge clk);
        chk("ready_after_pop", req_rdy, 1);
        wait_drain("drain_backpressure");
        chk("idle_busy", busy, 0);

        // In-flight read unaffected by a following write
        drive_rd(26'h010, 8'h1, part, 0, acc);
        drive_wr(26'h010, be_all, zero);
        drive_rd(26'h010, 8'h2, zero, 0, acc);
        idle();
        wait_drain("drain_snapshot");

        // Address aliasing above the array index
        drive_wr(26'h010, be_all, pat);
        drive_rd(26'h410, 8'h5, pat, 0, acc);
        drive_wr(26'h7FF, be_all, pat3c);
        drive_rd(26'h3FF, 8'h6, pat3c, 0, acc);
        idle();
        wait_drain("drain_wrap");

        // Reset with reads in flight
        drive_rd(26'h010, 8'h7, pat, 0, acc);
        drive_rd(26'h010, 8'h8, pat, 0, acc);
        drive_rd(26'h010, 8'h9, pat, 0, acc);
        @(negedge clk);
        req_vld = 1'b0;
        reset   = 1'b0;
        sb.delete();
        #1;
        chk("midrst_rsp_valid", rsp_vld, 0);
        chk("midrst_rsp_data", rsp_dat, zero);
        chk("midrst_rsp_tag", rsp_tag, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_req_ready", req_rdy, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1 chk("midrst_ready_after_release", req_rdy, 1);
        repeat (12) @(negedge clk);
        #2;
        chk("post_rst_no_rsp", rsp_vld, 0);
        chk("post_rst_busy", busy, 0);
        chk("sb_empty_end", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
